cache_core: RTL and testbench

CACHE_CORE -- requirements
Module: cache_core

---
 rtl/cache_core_pkg.sv | 31 +++
 rtl/cache_core_if.sv | 39 +++
 rtl/cache_core.sv | 180 ++++++++++++++++++
 tb/tb_cache_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_core_pkg.sv
// Shared definitions for the direct-mapped write-back cache.
//   - default geometry: 4 KiB of data, 32 B lines, 32-bit words, 32-bit byte addresses
//   - derived default widths (offset / index / tag)
//   - controller state enum and the per-line record (valid, dirty, tag, data)
// The line record is sized from the default geometry.
package cache_core_pkg;

  localparam int DEF_SIZE      = 32768;
  localparam int DEF_LINE_SIZE = 256;
  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_ADDR_SIZE = 32;

  localparam int DEF_LINES    = DEF_SIZE / DEF_LINE_SIZE;
  localparam int DEF_OFFSET_W = $clog2(DEF_LINE_SIZE / 8);
  localparam int DEF_INDEX_W  = $clog2(DEF_LINES);
  localparam int DEF_TAG_W    = DEF_ADDR_SIZE - DEF_INDEX_W - DEF_OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  typedef struct packed {
    logic                     valid;
    logic                     dirty;
    logic [DEF_TAG_W-1:0]     tag;
    logic [DEF_LINE_SIZE-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_core_if.sv
// Bus interfaces around the cache.
//   cache_interface  : CPU <-> cache. master = CPU, slave = cache.
//     addr, valid, write, wr_data, wr_be (master -> slave); rd_data, ready (slave -> master)
//   memory_interface : cache <-> memory. master = cache, slave = memory.
//     addr, valid, write, wr_data (master -> slave); rd_data, ready (slave -> master)
interface cache_interface
  import cache_core_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE
);
  logic [ADDR_SIZE-1:0]   addr;
  logic                   valid;
  logic                   write;
  logic [WORD_SIZE-1:0]   wr_data;
  logic [WORD_SIZE/8-1:0] wr_be;
  logic [WORD_SIZE-1:0]   rd_data;
  logic                   ready;

  modport master (output addr, valid, write, wr_data, wr_be, input rd_data, ready);
  modport slave  (input addr, valid, write, wr_data, wr_be, output rd_data, ready);
endinterface

interface memory_interface
  import cache_core_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int LINE_SIZE = DEF_LINE_SIZE
);
  logic [ADDR_SIZE-1:0] addr;
  logic                 valid;
  logic                 write;
  logic [LINE_SIZE-1:0] wr_data;
  logic [LINE_SIZE-1:0] rd_data;
  logic                 ready;

  modport master (output addr, valid, write, wr_data, input rd_data, ready);
  modport slave  (input addr, valid, write, wr_data, output rd_data, ready);
endinterface

// File: rtl/cache_core.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Ports:
//   clk_i      : clock, all state changes on the rising edge
//   reset_i    : synchronous active-high reset (clears valid/dirty, aborts transfers)
//   cache_bus  : CPU side (cache_interface.slave); hits complete in the request cycle
//   memory_bus : memory side (memory_interface.master); whole-line write-back and fill
//   hit_count, miss_count : first-cycle hit/miss counters, present only when the
//                           CACHE_STATS_EN macro is defined
module cache_core
  import cache_core_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int LINE_SIZE = DEF_LINE_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic            clk_i,
  input  logic            reset_i,
  cache_interface.slave   cache_bus,
  memory_interface.master memory_bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int LINES    = SIZE / LINE_SIZE;
  localparam int OFFSET_W = $clog2(LINE_SIZE / 8);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = ADDR_SIZE - INDEX_W - OFFSET_W;
  localparam int BYTES    = WORD_SIZE / 8;
  localparam int BYTE_W   = $clog2(BYTES);
  localparam int WSEL_W   = OFFSET_W - BYTE_W;

  state_e state_q, state_d;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [LINE_SIZE-1:0] data_mem [LINES];

  // Address split; the byte-within-word bits play no part in a word access.
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [WSEL_W-1:0]  word_sel;
  logic               unused_byte_bits;

  assign index            = cache_bus.addr[OFFSET_W +: INDEX_W];
  assign tag              = cache_bus.addr[ADDR_SIZE-1 -: TAG_W];
  assign word_sel         = cache_bus.addr[BYTE_W +: WSEL_W];
  assign unused_byte_bits = ^cache_bus.addr[BYTE_W-1:0];

  line_t                cur_line;
  logic                 hit;
  logic [LINE_SIZE-1:0] merged_line;
  logic                 wr_hit;
  logic                 wb_done;
  logic                 fill_done;

  always_comb begin
    cur_line.valid = valid_q[index];
    cur_line.dirty = dirty_q[index];
    cur_line.tag   = tag_mem[index];
    cur_line.data  = data_mem[index];
  end

  assign hit               = cur_line.valid && (cur_line.tag == tag);
  assign cache_bus.rd_data = cur_line.data[int'(word_sel)*WORD_SIZE +: WORD_SIZE];

  // Byte-enable merge of the CPU word into the resident line.
  always_comb begin
    merged_line = cur_line.data;
    for (int b = 0; b < BYTES; b++) begin
      if (cache_bus.wr_be[b]) begin
        merged_line[int'(word_sel)*WORD_SIZE + b*8 +: 8] = cache_bus.wr_data[b*8 +: 8];
      end
    end
  end

  // NOTE: every output of this block gets a default before the case statement so
  // that no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d            = state_q;
    cache_bus.ready    = 1'b0;
    memory_bus.valid   = 1'b0;
    memory_bus.write   = 1'b0;
    memory_bus.addr    = {tag, index, {OFFSET_W{1'b0}}};
    memory_bus.wr_data = cur_line.data;
    case (state_q)
      IDLE: begin
        if (cache_bus.valid) begin
          if (hit) begin
            cache_bus.ready = 1'b1;
          end else if (cur_line.valid && cur_line.dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        memory_bus.valid = 1'b1;
        memory_bus.write = 1'b1;
        memory_bus.addr  = {cur_line.tag, index, {OFFSET_W{1'b0}}};
        if (memory_bus.ready) state_d = FILL;
      end
      FILL: begin
        memory_bus.valid = 1'b1;
        if (memory_bus.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, but the bus must already look quiet while it is held.
    if (reset_i) begin
      state_d          = IDLE;
      cache_bus.ready  = 1'b0;
      memory_bus.valid = 1'b0;
    end
  end

  assign wr_hit    = cache_bus.ready && cache_bus.write;
  assign wb_done   = (state_q == WRITEBACK) && memory_bus.ready;
  assign fill_done = (state_q == FILL) && memory_bus.ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order the statements are written in.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_hit) dirty_q[index] <= 1'b1;
      if (wb_done) dirty_q[index] <= 1'b0;
      if (fill_done) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; cleared valid bits make their contents
  // irrelevant, and leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (wr_hit) data_mem[index] <= merged_line;
      if (fill_done) begin
        data_mem[index] <= memory_bus.rd_data;
        tag_mem[index]  <= tag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // retry_q marks an access that already missed, so its completing hit after the
  // fill is not counted a second time.
  logic retry_q;
  logic first_cycle;

  assign first_cycle = (state_q == IDLE) && cache_bus.valid && !retry_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retry_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (first_cycle) begin
        if (hit) hit_count  <= hit_count + 32'd1;
        else     miss_count <= miss_count + 32'd1;
      end
      if ((state_q == IDLE) && cache_bus.valid && !hit) retry_q <= 1'b1;
      else if (cache_bus.ready)                         retry_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cache_core.sv
// Directed bench for cache_core: a line-level reference model (resident line per
// index, line contents, dirty flag) plus a latency-5 memory responder predict
// hit/miss, read data and the exact memory transaction sequence of each access.
`timescale 1ns/1ps
module tb_cache_core;

  localparam int MEM_LAT = 5;
  localparam int TIMEOUT = 60;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  cache_interface  cbus ();
  memory_interface mbus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_core dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .cache_bus  (cbus),
    .memory_bus (mbus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- backing memory ----------------
  logic [255:0] mem_store [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    int unsigned  key;
    key = int'(la >> 5);
    if (mem_store.exists(key)) return mem_store[key];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(int'(la >> 2) + w);
    return l;
  endfunction

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [255:0] d;
  } txn_t;
  txn_t log_q[$];

  initial begin : mem_model
    int           lat;
    logic [31:0]  cap_addr;
    logic         cap_w;
    logic [255:0] cap_d;
    lat = 0;
    cap_addr = '0;
    cap_w = 1'b0;
    cap_d = '0;
    mbus.ready = 1'b0;
    mbus.rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mbus.ready = 1'b0;
      if (mbus.valid === 1'b1) begin
        if (lat == 0) begin
          cap_addr = mbus.addr;
          cap_w    = mbus.write;
          cap_d    = mbus.wr_data;
        end else begin
          check("mem_hold_addr", mbus.addr, cap_addr);
          check("mem_hold_write", mbus.write, cap_w);
          if (cap_w) check("mem_hold_data", mbus.wr_data, cap_d);
        end
        lat++;
        if (lat == MEM_LAT) begin
          log_q.push_back('{cap_w, cap_addr, cap_d});
          if (cap_w) mem_store[int'(cap_addr >> 5)] = cap_d;
          else       mbus.rd_data = mem_line(cap_addr);
          mbus.ready = 1'b1;
          lat = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // ---------------- cache reference model ----------------
  bit           m_valid [128];
  bit           m_dirty [128];
  logic [31:0]  m_la    [128];
  logic [255:0] m_data  [128];

  logic        rd_chk_en = 1'b0;
  logic [31:0] exp_rd    = '0;

  // Per-cycle compare: quiet bus when idle or in reset, and the predicted word
  // whenever the cache signals completion.
  always @(negedge clk) begin
    if (reset_i || cbus.valid !== 1'b1) check("ready_quiet", cbus.ready, 1'b0);
    if (reset_i) check("mvalid_in_reset", mbus.valid, 1'b0);
    if (rd_chk_en && cbus.ready === 1'b1) check("rd_data", cbus.rd_data, exp_rd);
  end

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd);
    int           idx;
    int           wsel;
    int           n;
    logic [31:0]  la;
    logic         exp_hit;
    logic         exp_wb;
    logic [31:0]  vic_la;
    logic [255:0] vic_data;
    logic [255:0] line;

    idx      = int'(a[11:5]);
    wsel     = int'(a[4:2]);
    la       = {a[31:5], 5'd0};
    exp_hit  = m_valid[idx] && (m_la[idx] == la);
    exp_wb   = !exp_hit && m_valid[idx] && m_dirty[idx];
    vic_la   = m_la[idx];
    vic_data = m_data[idx];
    line     = exp_hit ? m_data[idx] : mem_line(la);

    log_q.delete();
    exp_rd       = line[wsel*32 +: 32];
    rd_chk_en    = 1'b1;
    cbus.addr    = a;
    cbus.write   = w;
    cbus.wr_data = d;
    cbus.wr_be   = be;
    cbus.valid   = 1'b1;

    @(negedge clk);
    check("first_cycle_ready", cbus.ready, exp_hit);
    n = 0;
    while (cbus.ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", n < TIMEOUT, 1'b1);
    rd = cbus.rd_data;
    @(posedge clk);
    #1;
    cbus.valid = 1'b0;
    rd_chk_en  = 1'b0;

    check("mem_txn_count", log_q.size(), exp_hit ? 0 : (exp_wb ? 2 : 1));
    if (!exp_hit && log_q.size() == (exp_wb ? 2 : 1)) begin
      if (exp_wb) begin
        check("wb_write", log_q[0].w, 1'b1);
        check("wb_addr", log_q[0].a, vic_la);
        check("wb_data", log_q[0].d, vic_data);
      end
      check("fill_write", log_q[exp_wb ? 1 : 0].w, 1'b0);
      check("fill_addr", log_q[exp_wb ? 1 : 0].a, la);
    end

    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_la[idx]    = la;
      m_data[idx]  = line;
    end
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_data[idx][wsel*32 + b*8 +: 8] = d[b*8 +: 8];
      m_dirty[idx] = 1'b1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [31:0]  rd;
    logic [255:0] l;
    int           n;

    cbus.valid   = 1'b0;
    cbus.write   = 1'b0;
    cbus.addr    = '0;
    cbus.wr_data = '0;
    cbus.wr_be   = '0;
    model_reset();
    l = mem_line(32'h100);
    l[31:0] = 32'hDEADBEEF;
    mem_store[int'(32'h100 >> 5)] = l;

    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("reset_ready", cbus.ready, 1'b0);
    check("reset_mvalid", mbus.valid, 1'b0);

    // Cold read miss, then the same word hits.
    access(32'h0000_0100, 1'b0, '0, 4'h0, rd);
    check("lit_fill_deadbeef", rd, 32'hDEADBEEF);
    access(32'h0000_0100, 1'b0, '0, 4'h0, rd);
    check("lit_hit_deadbeef", rd, 32'hDEADBEEF);

    // Partial write hit, then read back merged word and a neighbour.
    access(32'h0000_0100, 1'b1, 32'h1122_3344, 4'b0011, rd);
    access(32'h0000_0100, 1'b0, '0, 4'h0, rd);
    check("lit_merged", rd, 32'hDEAD3344);
    access(32'h0000_0104, 1'b0, '0, 4'h0, rd);

    // Same index, new tag: dirty victim written back, then fill.
    access(32'h0000_1100, 1'b0, '0, 4'h0, rd);
    l = mem_line(32'h100);
    check("lit_wb_word0", l[31:0], 32'hDEAD3344);

    // Write-allocate miss, misaligned read-back, byte-lane write.
    access(32'h0000_2000, 1'b1, 32'hCAFE_F00D, 4'hF, rd);
    access(32'h0000_2002, 1'b0, '0, 4'h0, rd);
    check("lit_write_alloc", rd, 32'hCAFEF00D);
    access(32'h0000_2004, 1'b1, 32'hAB00_0000, 4'b1000, rd);
    access(32'h0000_2004, 1'b0, '0, 4'h0, rd);

    // Refetch of the written-back line (clean victim, no write-back).
    access(32'h0000_0100, 1'b0, '0, 4'h0, rd);
    check("lit_refetch", rd, 32'hDEAD3344);

    // Reset in the middle of a fill.
    cbus.addr  = 32'h0000_4040;
    cbus.write = 1'b0;
    cbus.valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mbus.valid !== 1'b1 && n < TIMEOUT);
    check("fill_start_timeout", n < TIMEOUT, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset_i    = 1'b1;
    cbus.valid = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_mvalid", mbus.valid, 1'b0);
    check("abort_ready", cbus.ready, 1'b0);
`ifdef CACHE_STATS_EN
    check("stats_hit_reset", hit_count, 32'd0);
    check("stats_miss_reset", miss_count, 32'd0);
`endif

    // Dirty 0x2000 data was lost: miss again, no write-back, memory contents return.
    access(32'h0000_2000, 1'b0, '0, 4'h0, rd);
    check("lit_lost_dirty", rd === 32'hCAFEF00D, 1'b0);
    access(32'h0000_2000, 1'b0, '0, 4'h0, rd);
    access(32'h0000_2004, 1'b0, '0, 4'h0, rd);
`ifdef CACHE_STATS_EN
    check("stats_miss", miss_count, 32'd1);
    check("stats_hit", hit_count, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
